// File: rtl/role_quiesce_ctrl.sv
// Role quiesce controller: tracks outstanding AXI transactions on the role
// memory master and DMA slave, gates new address issue, drains (or times out),
// then isolates the role and holds it in reset. Release runs the reverse path.
module role_quiesce_ctrl #(
  parameter int OUTST_W    = 4,
  parameter int TIMEOUT    = 4096,
  parameter int RST_CYCLES = 16
) (
  input  logic aclk,
  input  logic areset,
  input  logic quiesce_req,
  input  logic mem_aw_hs,
  input  logic mem_ar_hs,
  input  logic mem_b_hs,
  input  logic mem_rlast_hs,
  input  logic dma_aw_hs,
  input  logic dma_ar_hs,
  input  logic dma_b_hs,
  input  logic dma_rlast_hs,
  output logic block_addr,
  output logic decouple,
  output logic role_resetn,
  output logic quiesced,
  output logic timeout_err,
  output logic cnt_err
);

  localparam int NCNT = 4;  // mem_wr, mem_rd, dma_wr, dma_rd
  localparam int TMAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    S_INIT, S_RUN, S_BLOCK, S_ISO, S_RST, S_HOLD, S_REL
  } state_t;

  state_t                        state;
  logic [TW-1:0]                 timer;
  logic [NCNT-1:0]               inc, dec, dec_err;
  logic [NCNT-1:0][OUTST_W-1:0]  cnt, cnt_nxt;
  logic                          cnt_en, cnt_clr, idle, err_clr;

  assign inc = {dma_ar_hs,    dma_aw_hs, mem_ar_hs,    mem_aw_hs};
  assign dec = {dma_rlast_hs, dma_b_hs,  mem_rlast_hs, mem_b_hs};

  // Decoupler terminates the channels while isolated, so handshakes then are not real traffic.
  assign cnt_en  = !decouple;
  // Role is in reset: nothing can be outstanding.
  assign cnt_clr = (state == S_INIT) || (state == S_RST);
  // Live compare on current counts so drain completion is seen without an extra cycle.
  assign idle    = (cnt == '0);
  assign err_clr = (state == S_RUN) && quiesce_req;

  // Per-counter saturating up/down with underflow detect.
  for (genvar gi = 0; gi < NCNT; gi++) begin : g_cnt
    logic up, dn;
    assign up = cnt_en && inc[gi] && !dec[gi];
    assign dn = cnt_en && dec[gi] && !inc[gi];
    assign cnt_nxt[gi] = (up && cnt[gi] != '1) ? cnt[gi] + OUTST_W'(1) :
                         (dn && cnt[gi] != '0) ? cnt[gi] - OUTST_W'(1) :
                                                 cnt[gi];
    assign dec_err[gi] = dn && (cnt[gi] == '0);
  end

  // Outstanding counter state.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)       cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else              cnt <= cnt_nxt;
  end

  // Sticky underflow flag, cleared when a new quiesce starts.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) cnt_err <= 1'b0;
    else        cnt_err <= (cnt_err && !err_clr) || (|dec_err);
  end

  // Sequencer; outputs are registered alongside the state they belong to.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= S_INIT;
      timer       <= '0;
      block_addr  <= 1'b0;
      decouple    <= 1'b0;
      role_resetn <= 1'b0;
      quiesced    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          decouple    <= 1'b1;
          role_resetn <= 1'b0;
          if (timer == TW'(RST_CYCLES - 1)) begin
            state       <= S_REL;
            timer       <= '0;
            block_addr  <= 1'b1;
            role_resetn <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_RUN: begin
          block_addr  <= 1'b0;
          decouple    <= 1'b0;
          role_resetn <= 1'b1;
          if (quiesce_req) begin
            state       <= S_BLOCK;
            timer       <= '0;
            block_addr  <= 1'b1;
            timeout_err <= 1'b0;
          end
        end
        S_BLOCK: begin
          // Abort wins: requester changed its mind before isolation.
          if (!quiesce_req) begin
            state      <= S_RUN;
            block_addr <= 1'b0;
          end else if (idle) begin
            state    <= S_ISO;
            decouple <= 1'b1;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state       <= S_ISO;
            decouple    <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_ISO: begin
          state       <= S_RST;
          timer       <= '0;
          role_resetn <= 1'b0;
        end
        S_RST: begin
          if (timer == TW'(RST_CYCLES - 1)) begin
            state    <= S_HOLD;
            quiesced <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_HOLD: begin
          if (!quiesce_req) begin
            state       <= S_REL;
            timer       <= '0;
            quiesced    <= 1'b0;
            role_resetn <= 1'b1;
          end
        end
        S_REL: begin
          // Role leaves reset still isolated for two cycles before traffic opens.
          if (timer == TW'(1)) begin
            state      <= S_RUN;
            block_addr <= 1'b0;
            decouple   <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= S_INIT;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_role_quiesce_ctrl.sv
// Directed bench for role_quiesce_ctrl: reset/init, drain, abort,
// counter edge cases, timeout and reset-in-HOLD.
module tb_role_quiesce_ctrl;

  logic aclk = 1'b0;
  logic areset, quiesce_req;
  logic mem_aw_hs, mem_ar_hs, mem_b_hs, mem_rlast_hs;
  logic dma_aw_hs, dma_ar_hs, dma_b_hs, dma_rlast_hs;
  logic block_addr, decouple, role_resetn, quiesced, timeout_err, cnt_err;

  int errors = 0;
  int checks = 0;

  always #5 aclk = ~aclk;

  role_quiesce_ctrl #(.OUTST_W(4), .TIMEOUT(4096), .RST_CYCLES(16)) dut (
    .aclk(aclk), .areset(areset), .quiesce_req(quiesce_req),
    .mem_aw_hs(mem_aw_hs), .mem_ar_hs(mem_ar_hs), .mem_b_hs(mem_b_hs),
    .mem_rlast_hs(mem_rlast_hs), .dma_aw_hs(dma_aw_hs), .dma_ar_hs(dma_ar_hs),
    .dma_b_hs(dma_b_hs), .dma_rlast_hs(dma_rlast_hs),
    .block_addr(block_addr), .decouple(decouple), .role_resetn(role_resetn),
    .quiesced(quiesced), .timeout_err(timeout_err), .cnt_err(cnt_err)
  );

  // Advance n clocks; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic b, input logic d,
                         input logic r, input logic q);
    chk({tag, ".block_addr"},  block_addr,  b);
    chk({tag, ".decouple"},    decouple,    d);
    chk({tag, ".role_resetn"}, role_resetn, r);
    chk({tag, ".quiesced"},    quiesced,    q);
  endtask

  initial begin
    areset = 1'b1; quiesce_req = 1'b0;
    mem_aw_hs = 0; mem_ar_hs = 0; mem_b_hs = 0; mem_rlast_hs = 0;
    dma_aw_hs = 0; dma_ar_hs = 0; dma_b_hs = 0; dma_rlast_hs = 0;

    // Reset state
    tick(3);
    chk_out("rst", 0, 0, 0, 0);
    chk("rst.timeout_err", timeout_err, 0);
    chk("rst.cnt_err", cnt_err, 0);

    // INIT holds role in reset 16 cycles, then REL 2 cycles, then RUN
    areset = 1'b0;
    tick(1);
    chk_out("init1", 0, 1, 0, 0);
    tick(14);
    chk_out("init15", 0, 1, 0, 0);
    tick(1);
    chk_out("rel1", 1, 1, 1, 0);
    tick(1);
    chk_out("rel2", 1, 1, 1, 0);
    tick(1);
    chk_out("run0", 0, 0, 1, 0);

    // 2 mem AW + 1 dma AR outstanding, then quiesce must wait for drain
    mem_aw_hs = 1; dma_ar_hs = 1;
    tick(1);
    dma_ar_hs = 0;
    tick(1);
    mem_aw_hs = 0;
    quiesce_req = 1;
    tick(1);
    chk_out("blk1", 1, 0, 1, 0);
    tick(3);
    chk_out("blk4", 1, 0, 1, 0);
    mem_b_hs = 1;
    tick(2);
    mem_b_hs = 0;
    chk("drain_b.decouple", decouple, 0);
    dma_rlast_hs = 1;
    tick(1);
    dma_rlast_hs = 0;
    chk("drain_r.decouple", decouple, 0);
    tick(1);
    chk_out("iso", 1, 1, 1, 0);
    tick(1);
    chk_out("rst_st", 1, 1, 0, 0);
    tick(15);
    chk("rst16.quiesced", quiesced, 0);
    tick(1);
    chk_out("hold", 1, 1, 0, 1);
    chk("drain.timeout_err", timeout_err, 0);
    chk("drain.cnt_err", cnt_err, 0);
    // Handshakes while decoupled are ignored (no underflow flagged)
    mem_b_hs = 1;
    tick(1);
    mem_b_hs = 0;
    chk("hold_ign.cnt_err", cnt_err, 0);

    // Release
    quiesce_req = 0;
    tick(1);
    chk_out("rel_a", 1, 1, 1, 0);
    tick(2);
    chk_out("run1", 0, 0, 1, 0);

    // Same-cycle inc+dec at count 1 leaves count 1
    mem_aw_hs = 1;
    tick(1);
    mem_b_hs = 1;
    tick(1);
    mem_aw_hs = 0; mem_b_hs = 0;
    // Abort from BLOCK with count > 0
    quiesce_req = 1;
    tick(3);
    chk_out("abort_blk", 1, 0, 1, 0);
    quiesce_req = 0;
    tick(1);
    chk_out("abort_run", 0, 0, 1, 0);
    // Drain the single entry, then underflow
    mem_b_hs = 1;
    tick(1);
    chk("b_to0.cnt_err", cnt_err, 0);
    tick(1);
    mem_b_hs = 0;
    chk("underflow.cnt_err", cnt_err, 1);
    // Count held at 0: quiesce goes straight through; cnt_err clears on req
    quiesce_req = 1;
    tick(1);
    chk_out("lat_blk", 1, 0, 1, 0);
    chk("req_clr.cnt_err", cnt_err, 0);
    tick(1);
    chk_out("lat_iso", 1, 1, 1, 0);
    tick(1);
    chk_out("lat_rst", 1, 1, 0, 0);
    tick(16);
    chk_out("hold2", 1, 1, 0, 1);

    // areset in HOLD: immediate reset values, no quiesced glitch
    areset = 1'b1;
    #1;
    chk_out("hold_rst", 0, 0, 0, 0);
    tick(2);
    chk_out("hold_rst2", 0, 0, 0, 0);
    areset = 1'b0;
    quiesce_req = 0;
    tick(18);
    chk_out("run2", 0, 0, 1, 0);

    // Timeout: one mem AR never completes
    mem_ar_hs = 1;
    tick(1);
    mem_ar_hs = 0;
    quiesce_req = 1;
    tick(1);
    chk_out("to_blk", 1, 0, 1, 0);
    tick(4095);
    chk_out("to_4095", 1, 0, 1, 0);
    chk("to_4095.timeout_err", timeout_err, 0);
    tick(1);
    chk_out("to_iso", 1, 1, 1, 0);
    chk("to_iso.timeout_err", timeout_err, 1);
    tick(17);
    chk_out("to_hold", 1, 1, 0, 1);
    quiesce_req = 0;
    tick(3);
    chk_out("to_run", 0, 0, 1, 0);
    chk("to_sticky.timeout_err", timeout_err, 1);
    quiesce_req = 1;
    tick(1);
    chk("to_clr.timeout_err", timeout_err, 0);
    tick(1);
    chk_out("to_iso2", 1, 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
